// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | parking_gate_ctrl: password-gated car-park entrance with occupancy count |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module parking_gate_ctrl #(
  parameter int                  PW_WIDTH       = 4,
  parameter logic [PW_WIDTH-1:0] PASSWORD       = 4'b0110,
  parameter int                  CAPACITY       = 8,
  parameter int                  TIMEOUT_CYCLES = 16,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  LOCK_CYCLES    = 32,
  parameter int                  BLINK_DIV      = 2,
  localparam int                 OCC_W          = $clog2(CAPACITY + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                sensor_entrance_i,
  input  logic                sensor_exit_i,
  input  logic                car_leave_i,
  input  logic                pw_valid_i,
  input  logic [PW_WIDTH-1:0] pw_in_i,
  output logic                gate_open_o,
  output logic                green_led_o,
  output logic                red_led_o,
  output logic                full_o,
  output logic                lockout_o,
  output logic [OCC_W-1:0]    occupancy_o,
  output logic [6:0]          hex_1_o,
  output logic [6:0]          hex_2_o
);

  localparam int TM_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int TR_W = $clog2(MAX_TRIES + 1);
  localparam int BD_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [TM_W-1:0]  C_TIMER_LAST = TM_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LK_W-1:0]  C_LOCK_LAST  = LK_W'(LOCK_CYCLES - 1);
  localparam logic [TR_W-1:0]  C_TRIES_MAX  = TR_W'(MAX_TRIES);
  localparam logic [BD_W-1:0]  C_BLINK_LAST = BD_W'(BLINK_DIV - 1);
  localparam logic [OCC_W-1:0] C_OCC_MAX    = OCC_W'(CAPACITY);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_WRONG  = 3'd2;
  localparam logic [2:0] S_RIGHT  = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_LOCKED = 3'd5;

  localparam logic [6:0] C_SEG_OFF = 7'h7F;
  localparam logic [6:0] C_SEG_E   = 7'h06;
  localparam logic [6:0] C_SEG_N   = 7'h2B;
  localparam logic [6:0] C_SEG_6   = 7'h02;
  localparam logic [6:0] C_SEG_0   = 7'h40;
  localparam logic [6:0] C_SEG_5   = 7'h12;
  localparam logic [6:0] C_SEG_P   = 7'h0C;
  localparam logic [6:0] C_SEG_L   = 7'h47;

  logic [2:0]       state_q, state_d;
  logic [TR_W-1:0]  tries_q, tries_d;
  logic [TM_W-1:0]  timer_q, timer_d;
  logic [LK_W-1:0]  lock_q, lock_d;
  logic [BD_W-1:0]  bdiv_q;
  logic             blink_q;
  logic [OCC_W-1:0] occ_q;

  logic            good_w, bad_w, full_w, inc_w, blinking_w;
  logic [TR_W-1:0] tries_inc_w;

  assign good_w      = pw_valid_i && (pw_in_i == PASSWORD);
  assign bad_w       = pw_valid_i && (pw_in_i != PASSWORD);
  assign full_w      = (occ_q == C_OCC_MAX);
  assign tries_inc_w = tries_q + 1'b1;
  assign inc_w       = (state_q == S_RIGHT) && sensor_exit_i && !sensor_entrance_i;
  assign blinking_w  = (state_q == S_WRONG) || (state_q == S_RIGHT) || (state_q == S_STOP);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      tries_q <= '0;
      timer_q <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    timer_d = timer_q;
    lock_d  = lock_q;
    case (state_q)
      S_IDLE: begin
        if (sensor_entrance_i && !full_w) begin
          state_d = S_WAIT;
          tries_d = '0;
          timer_d = '0;
        end
      end
      S_WAIT, S_WRONG, S_STOP: begin
        if (state_q == S_WAIT) timer_d = timer_q + 1'b1;
        if (good_w) begin
          state_d = S_RIGHT;
        end else if (bad_w) begin
          tries_d = tries_inc_w;
          state_d = (tries_inc_w == C_TRIES_MAX) ? S_LOCKED : S_WRONG;
        end else if ((state_q == S_WAIT) && (timer_q == C_TIMER_LAST)) begin
          state_d = S_IDLE;
        end
      end
      S_RIGHT: begin
        if (sensor_entrance_i && sensor_exit_i) state_d = S_STOP;
        else if (sensor_exit_i)                 state_d = S_IDLE;
      end
      S_LOCKED: begin
        lock_d = lock_q + 1'b1;
        if (lock_q == C_LOCK_LAST) begin
          state_d = S_IDLE;
          tries_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_d == S_LOCKED) && (state_q != S_LOCKED)) lock_d = '0;
  end

  // Blink phase restarts off on every state change so each blinking state opens dark.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bdiv_q  <= '0;
      blink_q <= 1'b0;
    end else if (state_d != state_q) begin
      bdiv_q  <= '0;
      blink_q <= 1'b0;
    end else if (blinking_w) begin
      if (bdiv_q == C_BLINK_LAST) begin
        bdiv_q  <= '0;
        blink_q <= ~blink_q;
      end else begin
        bdiv_q <= bdiv_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      occ_q <= '0;
    end else if (inc_w && !car_leave_i) begin
      if (occ_q != C_OCC_MAX) occ_q <= occ_q + 1'b1;
    end else if (car_leave_i && !inc_w) begin
      if (occ_q != '0) occ_q <= occ_q - 1'b1;
    end
  end

  always_comb begin
    green_led_o = 1'b0;
    red_led_o   = 1'b0;
    gate_open_o = 1'b0;
    hex_1_o     = C_SEG_OFF;
    hex_2_o     = C_SEG_OFF;
    case (state_q)
      S_IDLE:   red_led_o = full_w;
      S_WAIT: begin
        red_led_o = 1'b1;
        hex_1_o   = C_SEG_E;
        hex_2_o   = C_SEG_N;
      end
      S_WRONG: begin
        red_led_o = blink_q;
        hex_1_o   = C_SEG_E;
        hex_2_o   = C_SEG_E;
      end
      S_RIGHT: begin
        green_led_o = blink_q;
        gate_open_o = 1'b1;
        hex_1_o     = C_SEG_6;
        hex_2_o     = C_SEG_0;
      end
      S_STOP: begin
        red_led_o = blink_q;
        hex_1_o   = C_SEG_5;
        hex_2_o   = C_SEG_P;
      end
      S_LOCKED: begin
        red_led_o = 1'b1;
        hex_1_o   = C_SEG_L;
        hex_2_o   = C_SEG_0;
      end
      default: ;
    endcase
  end

  assign full_o      = full_w;
  assign lockout_o   = (state_q == S_LOCKED);
  assign occupancy_o = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_parking_gate_ctrl: directed self-checking bench for parking_gate_ctrl |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_parking_gate_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_entrance = 1'b0, sensor_exit = 1'b0, car_leave = 1'b0;
  logic       pw_valid = 1'b0;
  logic [3:0] pw_in = 4'b0000;
  logic       gate_open, green_led, red_led, full, lockout;
  logic [3:0] occupancy;
  logic [6:0] hex_1, hex_2;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] C_GOOD = 4'b0110;
  localparam logic [3:0] C_BAD  = 4'b0000;

  always #5 clk = ~clk;

  parking_gate_ctrl dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .sensor_entrance_i (sensor_entrance),
    .sensor_exit_i     (sensor_exit),
    .car_leave_i       (car_leave),
    .pw_valid_i        (pw_valid),
    .pw_in_i           (pw_in),
    .gate_open_o       (gate_open),
    .green_led_o       (green_led),
    .red_led_o         (red_led),
    .full_o            (full),
    .lockout_o         (lockout),
    .occupancy_o       (occupancy),
    .hex_1_o           (hex_1),
    .hex_2_o           (hex_2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic attempt(input logic [3:0] pw);
    pw_valid = 1'b1;
    pw_in    = pw;
    tick();
    pw_valid = 1'b0;
    pw_in    = C_BAD;
  endtask

  task automatic enter_car();
    sensor_entrance = 1'b1; tick(); sensor_entrance = 1'b0;
    attempt(C_GOOD);
    sensor_exit = 1'b1; tick(); sensor_exit = 1'b0;
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_gate", gate_open, 0);
    chk("rst_green", green_led, 0);
    chk("rst_red", red_led, 0);
    chk("rst_full", full, 0);
    chk("rst_lock", lockout, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_hex", {hex_1, hex_2}, {7'h7F, 7'h7F});
    tick(); tick();
    reset = 1'b0;
    tick();

    // Good attempt on the 3rd WAIT cycle, then drive through
    sensor_entrance = 1'b1; tick(); sensor_entrance = 1'b0;
    chk("wait_hex", {hex_1, hex_2}, {7'h06, 7'h2B});
    chk("wait_red", red_led, 1);
    tick(); tick();
    attempt(C_GOOD);
    chk("right_gate", gate_open, 1);
    chk("right_hex", {hex_1, hex_2}, {7'h02, 7'h40});
    chk("right_green_c1", green_led, 0);
    tick();
    chk("right_green_c2", green_led, 0);
    tick();
    chk("right_green_c3", green_led, 1);
    sensor_exit = 1'b1; tick(); sensor_exit = 1'b0;
    chk("idle_after_exit_gate", gate_open, 0);
    chk("occ_1", occupancy, 1);

    // Three bad attempts -> lockout lasting 32 cycles
    sensor_entrance = 1'b1; tick(); sensor_entrance = 1'b0;
    attempt(C_BAD);
    chk("wrong1_hex", {hex_1, hex_2}, {7'h06, 7'h06});
    attempt(C_BAD);
    chk("wrong2_hex", {hex_1, hex_2}, {7'h06, 7'h06});
    chk("wrong2_lock", lockout, 0);
    attempt(C_BAD);
    chk("locked_lock", lockout, 1);
    chk("locked_red", red_led, 1);
    chk("locked_hex", {hex_1, hex_2}, {7'h47, 7'h40});
    attempt(C_GOOD);
    chk("locked_ignore_good", lockout, 1);
    chk("locked_ignore_gate", gate_open, 0);
    for (int i = 0; i < 30; i++) tick();
    chk("locked_cycle32", lockout, 1);
    tick();
    chk("unlocked", lockout, 0);
    chk("unlocked_hex", {hex_1, hex_2}, {7'h7F, 7'h7F});

    // Timeout after 16 idle WAIT cycles
    sensor_entrance = 1'b1; tick(); sensor_entrance = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("wait_cycle16", hex_2, 7'h2B);
    tick();
    chk("timeout_idle", {hex_1, hex_2}, {7'h7F, 7'h7F});

    // Attempt on cycle 16 beats the timeout; tries were cleared by the lockout exit
    sensor_entrance = 1'b1; tick(); sensor_entrance = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    attempt(C_BAD);
    chk("attempt_beats_timeout", {hex_1, hex_2}, {7'h06, 7'h06});
    chk("tries_cleared", lockout, 0);
    attempt(C_GOOD);
    chk("wrong_to_right", gate_open, 1);

    // Tailgating -> STOP, red blink with 2-cycle half-period
    sensor_entrance = 1'b1; sensor_exit = 1'b1; tick();
    sensor_entrance = 1'b0; sensor_exit = 1'b0;
    chk("stop_hex", {hex_1, hex_2}, {7'h12, 7'h0C});
    chk("stop_gate", gate_open, 0);
    chk("stop_red_c1", red_led, 0);
    tick(); tick();
    chk("stop_red_c3", red_led, 1);
    tick();
    chk("stop_red_c4", red_led, 1);
    tick();
    chk("stop_red_c5", red_led, 0);
    attempt(C_GOOD);
    chk("stop_to_right", gate_open, 1);
    sensor_exit = 1'b1; tick(); sensor_exit = 1'b0;
    chk("occ_2", occupancy, 2);

    // Fill the lot
    for (int i = 0; i < 6; i++) enter_car();
    chk("occ_8", occupancy, 8);
    chk("full_set", full, 1);
    chk("full_red", red_led, 1);
    sensor_entrance = 1'b1; tick(); sensor_entrance = 1'b0;
    chk("full_refuse", {hex_1, hex_2}, {7'h7F, 7'h7F});
    chk("full_refuse_red", red_led, 1);
    car_leave = 1'b1; tick(); car_leave = 1'b0;
    chk("leave_occ_7", occupancy, 7);
    chk("leave_full_clr", full, 0);
    sensor_entrance = 1'b1; tick(); sensor_entrance = 1'b0;
    chk("entry_after_leave", hex_1, 7'h06);
    attempt(C_GOOD);
    sensor_exit = 1'b1; tick(); sensor_exit = 1'b0;
    chk("refill_occ_8", occupancy, 8);

    // Increment and car_leave in the same cycle cancel
    car_leave = 1'b1; tick(); car_leave = 1'b0;
    sensor_entrance = 1'b1; tick(); sensor_entrance = 1'b0;
    attempt(C_GOOD);
    sensor_exit = 1'b1; car_leave = 1'b1; tick();
    sensor_exit = 1'b0; car_leave = 1'b0;
    chk("inc_dec_same", occupancy, 7);
    chk("inc_dec_idle", gate_open, 0);

    // Drain to zero, then one extra leave saturates
    for (int i = 0; i < 7; i++) begin
      car_leave = 1'b1; tick(); car_leave = 1'b0;
    end
    chk("drain_0", occupancy, 0);
    car_leave = 1'b1; tick(); car_leave = 1'b0;
    chk("sat_0", occupancy, 0);

    // Asynchronous reset mid-WRONG_PASS
    enter_car();
    chk("pre_rst_occ", occupancy, 1);
    sensor_entrance = 1'b1; tick(); sensor_entrance = 1'b0;
    attempt(C_BAD);
    tick(); tick();
    chk("pre_rst_red", red_led, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_red", red_led, 0);
    chk("mid_rst_hex", {hex_1, hex_2}, {7'h7F, 7'h7F});
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_misc", {gate_open, green_led, full, lockout}, 4'b0000);
    tick();
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Parametrised entrance-gate controller for the car park: admits one car at a time behind a password check and tracks lot occupancy up to a configurable capacity. It adds retry limiting with timed lockout, password-entry timeout, a full-lot refusal and configurable LED blink rate. It sits between the entrance/exit lane sensors and keypad and the gate actuator, LEDs and two 7-segment digits.

## Interface
- PW_WIDTH, 4, password width in bits
- PASSWORD, 4'b0110, accepted password (PW_WIDTH bits)
- CAPACITY, 8, parking spaces (≥1)
- TIMEOUT_CYCLES, 16, WAIT_PASSWORD cycles before abandoning entry
- MAX_TRIES, 3, wrong attempts that trigger lockout (≥1)
- LOCK_CYCLES, 32, LOCKED duration in cycles
- BLINK_DIV, 2, cycles per LED blink half-period (≥1)
- OCC_W, $clog2(CAPACITY+1), occupancy width (derived, localparam)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- sensor_entrance  in  1  car present at entrance gate
- sensor_exit  in  1  car has passed through gate into lot
- car_leave  in  1  one-cycle pulse: a car left the lot by the exit lane
- pw_valid  in  1  one-cycle strobe qualifying pw_in
- pw_in  in  PW_WIDTH  keypad password
- gate_open  out  1  gate actuator
- green_led  out  1  green LED
- red_led  out  1  red LED
- full  out  1  occupancy == CAPACITY
- lockout  out  1  state is LOCKED
- occupancy  out  OCC_W  cars in lot
- hex_1, hex_2  out  7  active-low segment codes (g..a)

## Operation
- States: IDLE, WAIT_PASSWORD, WRONG_PASS, RIGHT_PASS, STOP, LOCKED. Unused encodings go to IDLE.
- A good attempt is pw_valid=1 with pw_in==PASSWORD. A bad attempt is pw_valid=1 with any other value. pw_in is ignored while pw_valid=0.
- IDLE:
  - sensor_entrance=1 and full=0 → WAIT_PASSWORD; clear tries and the timer.
  - If full=1, stay in IDLE.
- WAIT_PASSWORD:
  - The timer increments every cycle.
  - Good attempt → RIGHT_PASS.
  - Bad attempt → tries+1, then WRONG_PASS, or LOCKED if the new tries == MAX_TRIES.
  - No attempt and timer == TIMEOUT_CYCLES-1 → IDLE.
  - An attempt takes priority over timeout.
- WRONG_PASS: good attempt → RIGHT_PASS; bad attempt handles tries and lockout as in WAIT_PASSWORD; no timeout.
- RIGHT_PASS:
  - sensor_entrance & sensor_exit → STOP (tailgating).
  - sensor_exit alone → IDLE; occupancy+1, saturating at CAPACITY.
- STOP: good attempt → RIGHT_PASS; bad attempt handles tries and lockout as above.
- LOCKED: all inputs except car_leave are ignored; after LOCK_CYCLES cycles → IDLE, with tries cleared.
- Occupancy:
  - car_leave decrements it, saturating at 0, in any state.
  - An increment and car_leave in the same cycle leave occupancy unchanged.
- Outputs per state (green / red / gate_open / hex_1 / hex_2):
  - IDLE: 0 / full / 0 / 7'h7F / 7'h7F
  - WAIT_PASSWORD: 0 / 1 / 0 / 7'h06 (E) / 7'h2B (n)
  - WRONG_PASS: 0 / blink / 0 / 7'h06 (E) / 7'h06 (E)
  - RIGHT_PASS: blink / 0 / 1 / 7'h02 (6) / 7'h40 (0)
  - STOP: 0 / blink / 0 / 7'h12 (5) / 7'h0C (P)
  - LOCKED: 0 / 1 / 0 / 7'h47 (L) / 7'h40 (0)
- Blink:
  - The phase register toggles every BLINK_DIV cycles while the state is WRONG_PASS, RIGHT_PASS or STOP.
  - It restarts at 0 with the divider cleared on every state change, so the first half-period is off.

## Timing
- Inputs are sampled on the rising clk edge. A state change is visible one cycle after the causing input.
- All outputs decode registered state, the blink phase and occupancy only. There is no combinational input→output path.
- occupancy updates on the same edge as the RIGHT_PASS→IDLE transition. full follows in the same cycle.
- Reset (at any time, including mid-entry or mid-lockout), all asynchronous:
  - State IDLE; tries, timer, lock counter, blink phase and occupancy = 0.
  - gate_open=0, green_led=0, red_led=0, full=0, lockout=0, hex_1=hex_2=7'h7F.
- Counter widths are sized from their parameters. No wrap: every counter is cleared on entry to the state that uses it.

## Test plan
- Reset, sensor_entrance=1, good attempt (pw_in=4'b0110) on the 3rd cycle of WAIT_PASSWORD → RIGHT_PASS, gate_open=1; sensor_exit=1 → IDLE, occupancy=1.
- Three bad attempts (4'b0000) → WRONG_PASS, WRONG_PASS, then LOCKED with lockout=1 and red_led=1. A good attempt during LOCKED is ignored. Exactly 32 cycles later → IDLE, lockout=0.
- No pw_valid for 16 cycles in WAIT_PASSWORD → IDLE; a pw_valid arriving on cycle 16 takes precedence.
- In RIGHT_PASS with sensor_entrance=sensor_exit=1 → STOP, hex=5/P. Good attempt → RIGHT_PASS. red_led blinks with a 2-cycle half-period in STOP.
- Fill to 8 cars → full=1. sensor_entrance stays in IDLE with red_led=1. A car_leave pulse gives occupancy=7 and the next entry proceeds. car_leave at occupancy 0 keeps it at 0.
- car_leave on the same cycle as sensor_exit in RIGHT_PASS → occupancy unchanged. Reset asserted mid-WRONG_PASS → all outputs reach their reset values immediately.
